// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Purpose : Shared state encoding, error codes and command bytes for PS/2 host.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_NOACK    = 2'b10;
  localparam logic [1:0] ERR_EDGE_TO  = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module  : ps2_line_filter
// Purpose : Synchronises PS/2 clock/data, debounces the clock, flags its falls.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic clk_fall
);
  localparam int c_cnt_w = $clog2(FILT_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_filt_last = c_cnt_w'(FILT_LEN - 1);

  logic clk_m_q, clk_s_q, data_m_q, data_s_q;
  logic filt_q, filt_d, prev_q;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // A new level is taken only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_s_q != filt_q) begin
      if (cnt_q == c_filt_last) filt_d = clk_s_q;
      else                      cnt_d  = cnt_q + c_cnt_w'(1);
    end
  end

  // Idle-high reset values keep a spurious fall from appearing after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_m_q  <= 1'b1;
      clk_s_q  <= 1'b1;
      data_m_q <= 1'b1;
      data_s_q <= 1'b1;
      filt_q   <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      clk_m_q  <= clk_in;
      clk_s_q  <= clk_m_q;
      data_m_q <= data_in;
      data_s_q <= data_m_q;
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      cnt_q    <= cnt_d;
    end
  end

  assign clk_filt  = filt_q;
  assign data_sync = data_s_q;
  assign clk_fall  = prev_q & ~filt_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Purpose : PS/2 host-to-device byte transmitter with ACK check and watchdog.
//           Optional macro PS2_TX_RETRY_EN: up to 2 retries, adds retry_cnt.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000,
  parameter int FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
`ifdef PS2_TX_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);
  localparam int c_cnt_w = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, FRAME_TIMEOUT) + 1);
  localparam logic [c_cnt_w-1:0] c_inh_last   = c_cnt_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(FRAME_TIMEOUT - 1);

  ps2_state_e state_q, state_d;
  logic [8:0] frame_q, frame_d;
  logic [3:0] idx_q, idx_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, done_q, done_d, idle_q, idle_d;
  logic [1:0] err_q, err_d;
  logic clk_f, data_s, fall;
  logic end_frame;
  logic [1:0] end_err;
  logic [9:0] bits;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_filt (clk_f),
    .data_sync(data_s),
    .clk_fall (fall)
  );

  // Serial order after the start bit: D0..D7, parity, stop (always 1).
  assign bits = {1'b1, frame_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b0;
      err_q   <= ERR_OK;
`ifdef PS2_TX_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    idle_d    = idle_q;
    err_d     = err_q;
    end_frame = 1'b0;
    end_err   = ERR_OK;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d = {~^tx_data, tx_data};
          err_d   = ERR_OK;
          cnt_d   = '0;
          state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == c_inh_last) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      REQ: begin
        state_d = SEND;
        cnt_d   = '0;
        idx_d   = '0;
        dout_d  = 1'b1;
      end
      SEND: begin
        if (fall) begin
          cnt_d  = '0;
          dout_d = ~bits[idx_q];
          idx_d  = idx_q + 4'd1;
          if (idx_q == 4'd9) state_d = ACK;
        end else if ((idx_q == 4'd0) ? (cnt_q == c_start_last) : (cnt_q == c_frame_last)) begin
          end_frame = 1'b1;
          end_err   = (idx_q == 4'd0) ? ERR_START_TO : ERR_EDGE_TO;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ACK: begin
        if (fall) begin
          err_d   = data_s ? ERR_NOACK : ERR_OK;
          idle_d  = 1'b0;
          state_d = WAIT_IDLE;
        end else if (cnt_q == c_frame_last) begin
          end_frame = 1'b1;
          end_err   = ERR_EDGE_TO;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      WAIT_IDLE: begin
        if (clk_f && data_s) begin
          if (idle_q) begin
            end_frame = 1'b1;
            end_err   = err_q;
          end else begin
            idle_d = 1'b1;
          end
        end else begin
          idle_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame end: either retry the same byte or report done/err and go idle.
    if (end_frame) begin
      err_d  = end_err;
      dout_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (((end_err == ERR_NOACK) || (end_err == ERR_EDGE_TO)) && (retry_q != 2'd2)) begin
        retry_d = retry_q + 2'd1;
        cnt_d   = '0;
        idle_d  = 1'b0;
        state_d = INHIBIT;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`else
      done_d  = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  always_comb begin
    ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    ps2_data_oe = (state_q == REQ) || ((state_q == SEND) && dout_q);
    busy        = (state_q != IDLE);
    tx_ready    = (state_q == IDLE);
  end

  assign done = done_q;
  assign err  = err_q;
`ifdef PS2_TX_RETRY_EN
  assign retry_cnt = retry_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// Scoreboarded bench for ps2_host_tx: a PS/2 device model clocks frames in,
// expected frames and done/err results are queued and checked by monitors.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int STO  = 400;
  localparam int FTO  = 200;
  localparam int HALF = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  typedef struct {
    logic [1:0] err;
    int kind;      // 0 none, 1 start-timeout timing, 2 edge-timeout timing
    int retries;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
  logic [1:0] err;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int send_start = 0;
  int last_fall = 0;
  int dev_mode = 0;
  bit dev_skip = 1'b0;
  bit dev_busy = 1'b0;
  exp_t exp_q[$];
  logic [10:0] frame_q[$];

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .FRAME_TIMEOUT (FTO),
    .FILT_LEN      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef PS2_TX_RETRY_EN
    ,
    .retry_cnt  (retry_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Reference frame as the device sees it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [1:0] mode_err(input int mode);
    case (mode)
      1:       return 2'b01;
      2:       return 2'b10;
      3:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Device model: answers a request-to-send by clocking the frame in.
  initial begin
    forever begin : dev_loop
      logic [10:0] samp;
      int nfall;
      @(negedge clk);
      if (rst && ps2_clk_in && !ps2_data_in) begin
        dev_busy = 1'b1;
        samp = '0;
        nfall = 0;
        repeat (20) @(negedge clk);
        if (dev_mode != 1) begin
          for (int k = 0; k < 11; k++) begin
            if (dev_mode == 3 && k == 4) break;
            samp[k] = ps2_data_in;
            dev_clk = 1'b0;
            last_fall = cyc;
            nfall++;
            if (k == 10 && dev_mode != 2) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            dev_data = 1'b1;
            repeat (HALF) @(negedge clk);
          end
        end
        if (nfall == 11 && !dev_skip) begin
          if (frame_q.size() == 0) check_eq("frame_unexpected", 1, 0);
          else check_eq("frame_bits", int'(samp), int'(frame_q.pop_front()));
        end
        wait (ps2_clk_oe || !busy || !rst);
        dev_busy = 1'b0;
      end
    end
  end

  // Line monitor: inhibit/request lengths and start of the device phase.
  initial begin
    int inh_n, req_n;
    logic prev_oe;
    inh_n = 0;
    req_n = 0;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inh_n = 0;
        req_n = 0;
      end else if (ps2_clk_oe) begin
        if (ps2_data_oe) req_n++;
        else inh_n++;
      end else if (prev_oe) begin
        check_eq("inhibit_cycles", inh_n, INH);
        check_eq("req_cycles", req_n, 1);
        send_start = cyc;
        inh_n = 0;
        req_n = 0;
      end
      prev_oe = ps2_clk_oe;
    end
  end

  // Result monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("err_at_done", int'(err), int'(e.err));
          check_eq("lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
          check_eq("ready_at_done", int'(tx_ready), 1);
          if (e.kind == 1) check_eq("start_timeout_latency", cyc - send_start, STO);
          if (e.kind == 2) check_range("edge_timeout_latency", cyc - last_fall, FTO, FTO + 20);
`ifdef PS2_TX_RETRY_EN
          check_eq("retry_cnt", int'(retry_cnt), e.retries);
`endif
        end
      end
    end
  end

  task automatic wait_dev_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!dev_busy) break;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit inject);
    exp_t e;
    bit ok;
    int prev;
    wait_dev_idle();
    e.err = mode_err(mode);
    e.kind = (mode == 1) ? 1 : ((mode == 3) ? 2 : 0);
    e.retries = (mode == 2 || mode == 3) ? RETRIES : 0;
    dev_mode = mode;
    if (mode == 0) frame_q.push_back(exp_frame(b));
    if (mode == 2) for (int i = 0; i <= RETRIES; i++) frame_q.push_back(exp_frame(b));
    exp_q.push_back(e);
    prev = done_cnt;
    @(negedge clk);
    check_eq("ready_before_tx", int'(tx_ready), 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("busy_after_accept", int'(busy), 1);
    if (inject) begin
      repeat (60) @(negedge clk);
      tx_data = ~b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done_cnt != prev) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("done_seen", int'(ok), 1);
    repeat (4) @(negedge clk);
    check_eq("err_held", int'(err), int'(e.err));
    check_eq("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int prev;
    int m;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_ready", int'(tx_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    send(8'hED, 0, 1'b0);
    send(8'h07, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    send(8'h5A, 1, 1'b0);
    send(8'h3C, 2, 1'b0);
    send(8'hA5, 3, 1'b0);

    // Reset mid-SEND while the host is driving a 0 data bit.
    wait_dev_idle();
    dev_mode = 0;
    dev_skip = 1'b1;
    prev = done_cnt;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!ps2_clk_oe) break;
      @(negedge clk);
    end
    repeat (150) @(negedge clk);
    check_eq("pre_rst_data_oe", int'(ps2_data_oe), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_clk_oe", int'(ps2_clk_oe), 0);
    check_eq("async_rst_data_oe", int'(ps2_data_oe), 0);
    check_eq("async_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_dev_idle();
    dev_skip = 1'b0;
    check_eq("no_done_on_reset", done_cnt, prev);

    send(8'hC3, 0, 1'b1);
    send(8'h96, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      m = $urandom_range(0, 3);
      send(8'($urandom), (m == 3) ? 3 : ((m == 2) ? 2 : 0), 1'b0);
    end

    repeat (20) @(negedge clk);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    check_eq("frames_empty", frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got %0d want 0", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
